// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants.
// Intended to be shared by the transmitter and a future receiver.
package uart_pkg;

    localparam int CLKS_PER_BIT_50M_9600 = 5208;
    localparam int UART_DATA_W           = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// 8N(STOP_BITS) UART transmitter, LSB first, idle-high line.
// Optional even-parity bit between data and stop bits when UART_TX_PARITY_EN
// is defined; the default build sends no parity.
// Bit timing is a single counter cleared on frame accept, so every bit edge is
// aligned to the clock edge that accepted the byte. All outputs are flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_9600,
    parameter int STOP_BITS    = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic                   i_Tx_DV,
    input  logic [UART_DATA_W-1:0] i_Tx_Byte,
    output logic                   o_Tx_Ready,
    output logic                   o_Tx_Active,
    output logic                   o_Tx_Serial,
    output logic                   o_Tx_Done
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;   // data index, then stop-bit index
    logic [UART_DATA_W-1:0] shift_q, shift_d;       // shift_q[0] is the bit on the line
    logic                   serial_q, serial_d;
    logic                   ready_q, ready_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (clk_cnt_q == CNT_LAST);

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so they change on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        ready_d   = ready_q;
        active_d  = active_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Tx_DV) begin
                    state_d   = START;
                    shift_d   = i_Tx_Byte;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    ready_d   = 1'b0;
                    active_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^i_Tx_Byte;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                    serial_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        serial_d  = parity_q;
`else
                        state_d   = STOP;
                        serial_d  = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                    serial_d  = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        ready_d   = 1'b1;
                        active_d  = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                serial_d  = 1'b1;
                ready_d   = 1'b1;
                active_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            active_q  <= active_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule : uart_tx
